// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: parses UART RX command frames, drives the register
// file and ALU, and streams read/ALU results back to the TX side.
module rx_cmd_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ALU_W  = 16
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              rx_d_valid,
  input  logic [DATA_W-1:0] rx_p_data,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic              alu_en,
  output logic [3:0]        alu_fun,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_out_valid,
  output logic              alu_clk_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              cmd_err
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] ALU_A    = 4'd5;
  localparam logic [3:0] ALU_B    = 4'd6;
  localparam logic [3:0] ALU_FUN  = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_RD    = 4'd9;
  localparam logic [3:0] TX_LO    = 4'd10;
  localparam logic [3:0] TX_GAP   = 4'd11;
  localparam logic [3:0] TX_HI    = 4'd12;

  localparam logic [DATA_W-1:0] OP_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OP_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OP_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OP_FUN = DATA_W'(8'hDD);

  logic [3:0]        state;
  logic              alu_start;
  logic [DATA_W-1:0] res_hi;
  logic              tx_acc;
  logic              rx_drop;

  assign tx_acc = tx_valid && !tx_busy;

  // Bytes that arrive while a result is pending or being sent are lost.
  assign rx_drop = rx_d_valid &&
                   (state == RD_WAIT || state == ALU_WAIT ||
                    state == TX_RD   || state == TX_LO    ||
                    state == TX_GAP  || state == TX_HI);

  always_ff @(posedge clk) begin
    if (rest) begin
      state      <= IDLE;
      alu_start  <= 1'b0;
      res_hi     <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      alu_en     <= 1'b0;
      alu_fun    <= '0;
      alu_clk_en <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rf_wr_en  <= 1'b0;
      rf_rd_en  <= 1'b0;
      alu_en    <= alu_start;
      alu_start <= 1'b0;
      cmd_err   <= rx_drop;
      unique case (state)
        IDLE: begin
          if (rx_d_valid) begin
            unique case (1'b1)
              (rx_p_data == OP_WR):  state <= WR_ADDR;
              (rx_p_data == OP_RD):  state <= RD_ADDR;
              (rx_p_data == OP_ALU): state <= ALU_A;
              (rx_p_data == OP_FUN): state <= ALU_FUN;
              default:               cmd_err <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (rx_d_valid) begin
            rf_addr <= rx_p_data[ADDR_W-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_d_valid) begin
            rf_wr_data <= rx_p_data;
            rf_wr_en   <= 1'b1;
            state      <= IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_d_valid) begin
            rf_addr  <= rx_p_data[ADDR_W-1:0];
            rf_rd_en <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rf_rd_valid) begin
            tx_data  <= rf_rd_data;
            tx_valid <= 1'b1;
            state    <= TX_RD;
          end
        end
        ALU_A: begin
          if (rx_d_valid) begin
            rf_addr    <= '0;
            rf_wr_data <= rx_p_data;
            rf_wr_en   <= 1'b1;
            state      <= ALU_B;
          end
        end
        ALU_B: begin
          if (rx_d_valid) begin
            rf_addr    <= ADDR_W'(1);
            rf_wr_data <= rx_p_data;
            rf_wr_en   <= 1'b1;
            state      <= ALU_FUN;
          end
        end
        ALU_FUN: begin
          if (rx_d_valid) begin
            alu_fun    <= rx_p_data[3:0];
            alu_clk_en <= 1'b1;
            alu_start  <= 1'b1;
            state      <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (alu_out_valid) begin
            tx_data    <= alu_out[DATA_W-1:0];
            res_hi     <= alu_out[ALU_W-1:DATA_W];
            tx_valid   <= 1'b1;
            alu_clk_en <= 1'b0;
            state      <= TX_LO;
          end
        end
        TX_RD: begin
          if (tx_acc) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        TX_LO: begin
          if (tx_acc) begin
            tx_valid <= 1'b0;
            state    <= TX_GAP;
          end
        end
        TX_GAP: begin
          tx_data  <= res_hi;
          tx_valid <= 1'b1;
          state    <= TX_HI;
        end
        TX_HI: begin
          if (tx_acc) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb_rx_cmd_ctrl: frame-level reference model, RF/ALU/TX responders
// and a queue scoreboard for rx_cmd_ctrl.
module tb_rx_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rest;
  logic        rx_d_valid;
  logic [7:0]  rx_p_data;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        alu_clk_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        cmd_err;

  rx_cmd_ctrl #(.DATA_W(8), .ADDR_W(4), .ALU_W(16)) dut (
    .clk(clk), .rest(rest),
    .rx_d_valid(rx_d_valid), .rx_p_data(rx_p_data),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data),
    .rf_rd_valid(rf_rd_valid),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out),
    .alu_out_valid(alu_out_valid), .alu_clk_en(alu_clk_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [11:0] q_wr[$];
  logic [3:0]  q_rd[$];
  logic [3:0]  q_alu[$];
  logic [8:0]  q_tx[$];
  int          err_exp = 0;
  int          err_seen = 0;

  logic [7:0]  env_mem[16];
  logic [7:0]  mdl_mem[16];
  int          rd_cnt = 0;
  int          alu_cnt = 0;
  int          rd_lat = 0;
  int          alu_lat = 0;
  logic [3:0]  rd_addr_q;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_f_q;
  logic        busy_rand = 1'b0;
  logic        hold_arm = 1'b0;
  int          hold_n = 0;

  // Behaviour of the external ALU as seen by this bench.
  function automatic logic [15:0] alu_model(logic [7:0] a, logic [7:0] b,
                                            logic [3:0] f);
    if (f == 4'd2) return 16'(a) + 16'(b);
    return (16'(a) * 16'(b)) ^ {4{f}};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register file, ALU and TX-side responders.
  initial begin
    rf_rd_valid = 0; rf_rd_data = 0;
    alu_out = 0; alu_out_valid = 0; tx_busy = 0;
    for (int i = 0; i < 16; i++) env_mem[i] = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rf_wr_en) env_mem[rf_addr] = rf_wr_data;
      rf_rd_valid = 1'b0;
      rf_rd_data = 8'($urandom);
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rf_rd_valid = 1'b1;
          rf_rd_data = env_mem[rd_addr_q];
        end
      end
      if (rf_rd_en) begin
        rd_cnt = (rd_lat > 0) ? rd_lat : int'($urandom_range(1, 3));
        rd_addr_q = rf_addr;
      end
      alu_out_valid = 1'b0;
      alu_out = 16'($urandom);
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          alu_out_valid = 1'b1;
          alu_out = alu_model(alu_a, alu_b, alu_f_q);
        end
      end
      if (alu_en) begin
        alu_cnt = (alu_lat > 0) ? alu_lat : int'($urandom_range(1, 4));
        alu_a = env_mem[0];
        alu_b = env_mem[1];
        alu_f_q = alu_fun;
      end
      if (hold_arm && tx_valid) begin
        hold_arm = 1'b0;
        hold_n = 20;
      end
      if (hold_n > 0) begin
        tx_busy = 1'b1;
        hold_n--;
      end else begin
        tx_busy = busy_rand && ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  logic       prev_hold = 0, prev_acc = 0, prev_aov = 0;
  logic       prev_clk_en = 0, prev_alu_en = 0;
  logic [7:0] prev_data = 0;
  int         gap_st = 0;

  initial begin
    logic [11:0] ew;
    logic [3:0]  er;
    logic [8:0]  et;
    forever begin
      @(negedge clk);
      if (rest) begin
        prev_hold = 0; prev_acc = 0; prev_aov = 0;
        prev_clk_en = 0; prev_alu_en = 0; gap_st = 0;
      end else begin
        if (prev_hold) begin
          chk("tx_hold_valid", 32'(tx_valid), 32'd1);
          chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (prev_acc) chk("tx_drop", 32'(tx_valid), 32'd0);
        if (gap_st == 1) gap_st = 2;
        else if (gap_st == 2) begin
          chk("tx_gap_end", 32'(tx_valid), 32'd1);
          gap_st = 0;
        end
        if (prev_aov) chk("clk_en_off", 32'(alu_clk_en), 32'd0);
        if (alu_out_valid) chk("clk_en_at_valid", 32'(alu_clk_en), 32'd1);
        if (rf_wr_en) begin
          chk("wr_rd_excl", 32'(rf_rd_en), 32'd0);
          chk("wr_expected", 32'(q_wr.size() != 0), 32'd1);
          if (q_wr.size() != 0) begin
            ew = q_wr.pop_front();
            chk("wr_addr", 32'(rf_addr), 32'(ew[11:8]));
            chk("wr_data", 32'(rf_wr_data), 32'(ew[7:0]));
          end
        end
        if (rf_rd_en) begin
          chk("rd_expected", 32'(q_rd.size() != 0), 32'd1);
          if (q_rd.size() != 0) begin
            er = q_rd.pop_front();
            chk("rd_addr", 32'(rf_addr), 32'(er));
          end
        end
        if (alu_en) begin
          chk("alu_clk_en_run", 32'(alu_clk_en), 32'd1);
          chk("alu_clk_en_lead", 32'(prev_clk_en), 32'd1);
          chk("alu_en_single", 32'(prev_alu_en), 32'd0);
          chk("alu_expected", 32'(q_alu.size() != 0), 32'd1);
          if (q_alu.size() != 0) begin
            er = q_alu.pop_front();
            chk("alu_fun", 32'(alu_fun), 32'(er));
          end
        end
        if (cmd_err) err_seen++;
        if (tx_valid && !tx_busy) begin
          chk("tx_expected", 32'(q_tx.size() != 0), 32'd1);
          if (q_tx.size() != 0) begin
            et = q_tx.pop_front();
            chk("tx_data", 32'(tx_data), 32'(et[7:0]));
            if (et[8]) gap_st = 1;
          end
        end
        prev_hold = tx_valid && tx_busy;
        prev_acc = tx_valid && !tx_busy;
        prev_data = tx_data;
        prev_aov = alu_out_valid;
        prev_clk_en = alu_clk_en;
        prev_alu_en = alu_en;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_d_valid = 1'b1;
    rx_p_data = b;
    @(posedge clk); #1;
    rx_d_valid = 1'b0;
    rx_p_data = 8'($urandom);
  endtask

  task automatic gap();
    if (busy_rand) idle(int'($urandom_range(0, 2)));
  endtask

  task automatic junk(int mode, logic [7:0] b);
    if (mode != 0) begin
      if (mode == 2) idle(1);
      err_exp++;
      send_byte(b);
    end
  endtask

  task automatic do_wr(logic [7:0] a, logic [7:0] d);
    q_wr.push_back({a[3:0], d});
    mdl_mem[a[3:0]] = d;
    send_byte(8'hAA); gap(); send_byte(a); gap(); send_byte(d);
  endtask

  task automatic do_rd(logic [7:0] a, int jm, logic [7:0] jb);
    q_rd.push_back(a[3:0]);
    q_tx.push_back({1'b0, mdl_mem[a[3:0]]});
    send_byte(8'hBB); gap(); send_byte(a);
    junk(jm, jb);
  endtask

  task automatic do_alu(logic [7:0] a, logic [7:0] b, logic [7:0] f,
                        int jm, logic [7:0] jb);
    logic [15:0] r;
    q_wr.push_back({4'd0, a});
    q_wr.push_back({4'd1, b});
    mdl_mem[0] = a;
    mdl_mem[1] = b;
    r = alu_model(a, b, f[3:0]);
    q_alu.push_back(f[3:0]);
    q_tx.push_back({1'b1, r[7:0]});
    q_tx.push_back({1'b0, r[15:8]});
    send_byte(8'hCC); gap(); send_byte(a); gap(); send_byte(b);
    gap(); send_byte(f);
    junk(jm, jb);
  endtask

  task automatic do_fun(logic [7:0] f, int jm, logic [7:0] jb);
    logic [15:0] r;
    r = alu_model(mdl_mem[0], mdl_mem[1], f[3:0]);
    q_alu.push_back(f[3:0]);
    q_tx.push_back({1'b1, r[7:0]});
    q_tx.push_back({1'b0, r[15:8]});
    send_byte(8'hDD); gap(); send_byte(f);
    junk(jm, jb);
  endtask

  task automatic bad_op(logic [7:0] b);
    err_exp++;
    send_byte(b);
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    idle(2);
    while (n < 400 && !(q_wr.size() == 0 && q_rd.size() == 0 &&
                        q_alu.size() == 0 && q_tx.size() == 0 &&
                        !tx_valid && rd_cnt == 0 && alu_cnt == 0)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_err_count"}, 32'(err_seen), 32'(err_exp));
    chk({tag, "_clk_en_idle"}, 32'(alu_clk_en), 32'd0);
    idle(1);
  endtask

  function automatic logic [31:0] outs();
    return 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                alu_clk_en, tx_data, tx_valid, cmd_err});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int k;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    rest = 1'b1;
    rx_d_valid = 1'b0;
    rx_p_data = 8'h00;
    idle(3);
    chk("reset_outputs", outs(), 32'd0);
    rest = 1'b0;
    idle(2);

    rd_lat = 2;
    alu_lat = 3;
    do_wr(8'h05, 8'h3C);
    wait_done("dir_wr");
    do_rd(8'h05, 0, 8'h00);
    wait_done("dir_rd");
    do_alu(8'h12, 8'h34, 8'h02, 0, 8'h00);
    wait_done("dir_alu");
    hold_arm = 1'b1;
    do_alu(8'h12, 8'h34, 8'h02, 0, 8'h00);
    wait_done("dir_alu_hold");
    bad_op(8'h7F);
    wait_done("dir_bad_op");
    do_alu(8'h12, 8'h34, 8'h02, 1, 8'hAA);
    wait_done("dir_alu_drop");

    send_byte(8'hAA);
    send_byte(8'h05);
    rest = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_outputs", outs(), 32'd0);
    rest = 1'b0;
    idle(1);
    bad_op(8'h3C);
    do_wr(8'h01, 8'h02);
    wait_done("dir_after_reset");

    rd_lat = 0;
    alu_lat = 0;
    busy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0: do_wr(8'($urandom), 8'($urandom));
        1: do_rd(8'($urandom), int'($urandom_range(0, 2)), 8'($urandom));
        2: do_alu(8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 2)), 8'($urandom));
        3: do_fun(8'($urandom), int'($urandom_range(0, 2)), 8'($urandom));
        default: begin
          b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD)
            b = 8'($urandom);
          bad_op(b);
        end
      endcase
      wait_done("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_cmd_ctrl.md
Name: rx_cmd_ctrl

Overview:
Command sequencer on the UART receive path. Consumes the byte stream from the UART receiver (d_valid/p_data) and parses multi-byte command frames. Drives the register file and ALU, and returns read or ALU results to the UART transmitter. Single clock domain, placed between the receiver output, the register file, the ALU and the TX input.

Parameters:
DATA_W, 8, byte width of RX/TX/register data
ADDR_W, 4, register file address width
ALU_W, 16, ALU result width (fixed at 2*DATA_W)

Ports:
clk  in  1  system clock
rest  in  1  synchronous active-high reset
rx_d_valid  in  1  one-cycle pulse, rx_p_data holds a received byte
rx_p_data  in  DATA_W  received byte
rf_wr_en  out  1  register write strobe, one cycle
rf_rd_en  out  1  register read strobe, one cycle
rf_addr  out  ADDR_W  register address
rf_wr_data  out  DATA_W  register write data
rf_rd_data  in  DATA_W  register read data
rf_rd_valid  in  1  read data valid; arrives 1 or more cycles after rf_rd_en
alu_en  out  1  ALU start, one-cycle pulse
alu_fun  out  4  ALU function code
alu_out  in  ALU_W  ALU result
alu_out_valid  in  1  result valid pulse
alu_clk_en  out  1  ALU clock-gate enable
tx_data  out  DATA_W  byte to transmit
tx_valid  out  1  byte offered to TX
tx_busy  in  1  TX serialising; a byte is accepted when tx_valid && !tx_busy
cmd_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (rest=1 at a clk edge): state=IDLE. All outputs are 0: strobes, rf_addr, rf_wr_data, alu_fun, alu_clk_en, tx_data, tx_valid and cmd_err. Reset aborts any command in progress. No partial register write occurs afterwards.
- Frame opcodes are taken from the first byte seen in IDLE:
  - 0xAA: register write. Frame is AA, addr, data.
  - 0xBB: register read. Frame is BB, addr.
  - 0xCC: ALU op with operands. Frame is CC, A, B, fun.
  - 0xDD: ALU op without operands. Frame is DD, fun.
- Address bytes use the low ADDR_W bits; the upper bits are ignored. Function bytes use the low 4 bits.
- States and transitions:
  - IDLE: opcode byte selects WR_ADDR, RD_ADDR, ALU_A or ALU_FUN. Any other byte gives a cmd_err pulse and the state stays IDLE.
  - WR_ADDR: byte is latched into rf_addr, then go to WR_DATA.
  - WR_DATA: byte is latched into rf_wr_data and rf_wr_en pulses in the cycle after the byte. Return to IDLE.
  - RD_ADDR: byte is latched into rf_addr and rf_rd_en pulses the next cycle. Go to RD_WAIT.
  - RD_WAIT: on rf_rd_valid, capture rf_rd_data into tx_data, then go to TX_RD.
  - ALU_A: rf_wr_en pulses with rf_addr=0 and data=A. Go to ALU_B.
  - ALU_B: rf_wr_en pulses with rf_addr=1 and data=B. Go to ALU_FUN.
  - ALU_FUN: byte is latched into alu_fun. alu_clk_en goes high in the same cycle, and alu_en pulses one cycle later. Go to ALU_WAIT.
  - ALU_WAIT: on alu_out_valid, capture alu_out, drop alu_clk_en, then go to TX_LO.
  - TX_RD, TX_LO, TX_HI: assert tx_valid and hold tx_data stable until accepted.
    - TX_LO sends alu_out[7:0], then goes to TX_GAP.
    - TX_GAP deasserts tx_valid for exactly 1 cycle, then goes to TX_HI.
    - TX_HI sends alu_out[15:8], then goes to IDLE.
    - TX_RD goes to IDLE on accept.
  - tx_valid drops in the cycle after accept.
- alu_clk_en stays high from ALU_FUN acceptance until the cycle alu_out_valid is seen. It is low in all other states.
- An rx_d_valid in RD_WAIT, ALU_WAIT or any TX state is dropped and pulses cmd_err. The state is unchanged.
- rx_d_valid and alu_out_valid (or rf_rd_valid) in the same cycle: the result capture proceeds and the byte is flagged with cmd_err.
- rf_rd_valid or alu_out_valid arriving in an unrelated state is ignored with no error.
- Only one rf strobe is active per cycle. rf_wr_en and rf_rd_en are never high together.
- No timeout; an incomplete frame waits indefinitely for its remaining bytes.

Test Plan:
- Bytes AA,05,3C → a single-cycle rf_wr_en with rf_addr=5 and rf_wr_data=0x3C; state returns to IDLE; cmd_err never pulses.
- Bytes BB,05; rf_rd_valid 2 cycles after rf_rd_en with rf_rd_data=0x3C; tx_busy=0 → tx_valid for 1 cycle with tx_data=0x3C.
- Bytes CC,12,34,02; alu_out=0x0046 valid 3 cycles after alu_en:
  - writes to addr0=0x12 and addr1=0x34;
  - alu_fun=2 and a single alu_en pulse;
  - alu_clk_en high until valid;
  - TX sends 0x46 then 0x00 with a 1-cycle gap.
- Same as previous, but tx_busy held high 20 cycles → tx_valid and tx_data=0x46 held stable all 20 cycles; accepted on the first cycle tx_busy=0.
- Byte 0x7F in IDLE → cmd_err pulse, no strobes. Byte 0xAA arriving during ALU_WAIT → cmd_err pulse, and the ALU result is still transmitted.
- rest asserted after AA,05 → all outputs 0 next cycle. The following bytes 3C,AA,01,02 produce exactly one write: addr1=0x02.
